// File: rtl/pipe_ctrl_pkg.sv
// ID/EX control-vector layout shared by decode, hazard and execute.
// Bit indices, default width and the no-op control word.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 10;

  localparam int RWE    = 0;
  localparam int ASRC   = 1;
  localparam int MWR    = 2;
  localparam int OP_LSB = 3;
  localparam int OP_MSB = 6;
  localparam int M2R    = 7;
  localparam int MRD    = 8;
  localparam int BR     = 9;

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [3:0] op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write_en;
  } ctrl_t;

endpackage

// File: rtl/bubble_countdown.sv
// Multi-bubble injection countdown: saturates requests, max-merges
// overlapping ones and reports inj_busy while bubbles remain.
module bubble_countdown #(
  parameter int MAX_BUB = 3,
  parameter int CNT_W   = $clog2(MAX_BUB + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             inj_req,
  input  logic [CNT_W-1:0] inj_cnt,
  output logic             inj_busy,
  output logic             inj_load
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BUB);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sat;
  logic [CNT_W-1:0] dec;
  logic [CNT_W-1:0] req_left;

  always_comb begin
    sat      = (inj_cnt > MAX_C) ? MAX_C : inj_cnt;
    dec      = (cnt != '0) ? cnt - ONE : '0;
    req_left = (sat != '0) ? sat - ONE : '0;
  end

  assign inj_load = inj_req & (inj_cnt != '0);
  assign inj_busy = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (stall) begin
      // no bubble is written while stalled, so keep the full request
      if (inj_load && (sat > cnt)) cnt <= sat;
    end else if (inj_load) begin
      cnt <= (dec > req_left) ? dec : req_left;
    end else begin
      cnt <= dec;
    end
  end

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ID/EX register with hold, bubble, multi-bubble injection and flush.
// Define CTRL_BUBBLE_STATS_EN to add the bubble_total counter port.
module ctrl_bubble_stage #(
  parameter int                CTRL_W   = 10,
  parameter int                DATA_W   = 64,
  parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
  parameter int                MAX_BUB  = 3,
  parameter int                CNT_W    = $clog2(MAX_BUB + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              bubble,
  input  logic              inj_req,
  input  logic [CNT_W-1:0]  inj_cnt,
  input  logic              flush,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              inj_busy,
  output logic              upstream_hold
`ifdef CTRL_BUBBLE_STATS_EN
  ,
  output logic [31:0]       bubble_total
`endif
);

  import pipe_ctrl_pkg::*;

  logic inj_load;
  logic bub_wr;

  bubble_countdown #(
    .MAX_BUB (MAX_BUB),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .inj_req  (inj_req),
    .inj_cnt  (inj_cnt),
    .inj_busy (inj_busy),
    .inj_load (inj_load)
  );

  assign bub_wr        = bubble | inj_busy | inj_load;
  assign upstream_hold = stall | inj_busy | inj_load;

  // bubbled slots keep the old payload to avoid toggling data_out
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_out  <= NOP_CTRL;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      ctrl_out  <= NOP_CTRL;
      valid_out <= 1'b0;
    end else if (!stall) begin
      if (bub_wr) begin
        ctrl_out  <= NOP_CTRL;
        valid_out <= 1'b0;
      end else begin
        ctrl_out  <= ctrl_in;
        data_out  <= data_in;
        valid_out <= valid_in;
      end
    end
  end

`ifdef CTRL_BUBBLE_STATS_EN
  logic bub_edge;
  assign bub_edge = flush | (!stall & bub_wr);

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_total <= '0;
    end else if (bub_edge && (bubble_total != '1)) begin
      bubble_total <= bubble_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Vector-table bench for ctrl_bubble_stage with an expected-output queue.
// Hand-derived expectations cover stall, bubble, injection and flush.
module tb_ctrl_bubble_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ctrl_in;
  logic [63:0] data_in;
  logic        valid_in;
  logic        stall;
  logic        bubble;
  logic        inj_req;
  logic [2:0]  inj_cnt;
  logic        flush;
  logic [9:0]  ctrl_out;
  logic [63:0] data_out;
  logic        valid_out;
  logic        inj_busy;
  logic        upstream_hold;
`ifdef CTRL_BUBBLE_STATS_EN
  logic [31:0] bubble_total;
`endif

  always #5 clk = ~clk;

  ctrl_bubble_stage #(
    .CTRL_W  (10),
    .DATA_W  (64),
    .MAX_BUB (3),
    .CNT_W   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_in       (ctrl_in),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .stall         (stall),
    .bubble        (bubble),
    .inj_req       (inj_req),
    .inj_cnt       (inj_cnt),
    .flush         (flush),
    .ctrl_out      (ctrl_out),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .inj_busy      (inj_busy),
    .upstream_hold (upstream_hold)
`ifdef CTRL_BUBBLE_STATS_EN
    ,
    .bubble_total  (bubble_total)
`endif
  );

  typedef struct {
    logic        r;
    logic [9:0]  c;
    logic [63:0] d;
    logic        v;
    logic        st;
    logic        bb;
    logic        ij;
    logic [2:0]  ic;
    logic        fl;
    logic        h;
    logic [9:0]  ec;
    logic [63:0] ed;
    logic        ev;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [9:0]  ec;
    logic [63:0] ed;
    logic        ev;
    logic        eb;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mk(
    input logic r, input logic [9:0] c, input logic [63:0] d,
    input logic v, input logic st, input logic bb, input logic ij,
    input logic [2:0] ic, input logic fl, input logic h,
    input logic [9:0] ec, input logic [63:0] ed,
    input logic ev, input logic eb);
    vec_t t;
    t.r = r; t.c = c; t.d = d; t.v = v; t.st = st; t.bb = bb;
    t.ij = ij; t.ic = ic; t.fl = fl; t.h = h;
    t.ec = ec; t.ed = ed; t.ev = ev; t.eb = eb;
    return t;
  endfunction

  task automatic chk(input string n, input int i,
                     input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s row %0d: got %0h, want %0h", n, i, act, req);
  endtask

  initial begin
    rst = 1'b1; ctrl_in = '0; data_in = '0; valid_in = 1'b0;
    stall = 1'b0; bubble = 1'b0; inj_req = 1'b0; inj_cnt = '0;
    flush = 1'b0;

    //                r  ctrl    data   v st bb ij ic fl  h  ectrl  edata  ev eb
    tbl.push_back(mk(1, 10'h3FF, 64'h11, 1, 0, 0, 0, 0, 0, 0, 10'h000, 64'h0, 0, 0));
    tbl.push_back(mk(1, 10'h3FF, 64'h11, 1, 0, 0, 0, 0, 0, 0, 10'h000, 64'h0, 0, 0));
    tbl.push_back(mk(0, 10'h2A5, 64'h22, 1, 0, 0, 0, 0, 0, 0, 10'h2A5, 64'h22, 1, 0));
    tbl.push_back(mk(0, 10'h155, 64'h33, 1, 0, 1, 0, 0, 0, 0, 10'h000, 64'h22, 0, 0));
    tbl.push_back(mk(0, 10'h0F0, 64'h44, 0, 0, 0, 0, 0, 0, 0, 10'h0F0, 64'h44, 0, 0));
    tbl.push_back(mk(0, 10'h111, 64'h55, 1, 0, 0, 1, 3, 0, 1, 10'h000, 64'h44, 0, 1));
    tbl.push_back(mk(0, 10'h122, 64'h66, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h44, 0, 1));
    tbl.push_back(mk(0, 10'h133, 64'h77, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h44, 0, 0));
    tbl.push_back(mk(0, 10'h144, 64'h88, 1, 0, 0, 0, 0, 0, 0, 10'h144, 64'h88, 1, 0));
    tbl.push_back(mk(0, 10'h155, 64'h99, 1, 0, 0, 1, 7, 0, 1, 10'h000, 64'h88, 0, 1));
    tbl.push_back(mk(0, 10'h166, 64'hAA, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h88, 0, 1));
    tbl.push_back(mk(0, 10'h177, 64'hBB, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h88, 0, 0));
    tbl.push_back(mk(0, 10'h188, 64'hCC, 1, 0, 0, 0, 0, 0, 0, 10'h188, 64'hCC, 1, 0));
    tbl.push_back(mk(0, 10'h199, 64'hDD, 1, 0, 0, 1, 2, 0, 1, 10'h000, 64'hCC, 0, 1));
    tbl.push_back(mk(0, 10'h1AA, 64'hEE, 1, 1, 0, 0, 0, 0, 1, 10'h000, 64'hCC, 0, 1));
    tbl.push_back(mk(0, 10'h1BB, 64'hFF, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'hCC, 0, 0));
    tbl.push_back(mk(0, 10'h1CC, 64'h100, 1, 0, 0, 0, 0, 0, 0, 10'h1CC, 64'h100, 1, 0));
    tbl.push_back(mk(0, 10'h1DD, 64'h111, 1, 0, 0, 1, 3, 1, 1, 10'h000, 64'h100, 0, 0));
    tbl.push_back(mk(0, 10'h1EE, 64'h122, 1, 0, 0, 0, 0, 0, 0, 10'h1EE, 64'h122, 1, 0));
    tbl.push_back(mk(0, 10'h1FF, 64'h133, 1, 1, 0, 0, 0, 1, 1, 10'h000, 64'h122, 0, 0));
    tbl.push_back(mk(0, 10'h200, 64'h144, 1, 1, 0, 0, 0, 0, 1, 10'h000, 64'h122, 0, 0));
    tbl.push_back(mk(0, 10'h211, 64'h155, 1, 0, 0, 1, 0, 0, 0, 10'h211, 64'h155, 1, 0));
    tbl.push_back(mk(0, 10'h222, 64'h166, 1, 0, 0, 1, 1, 0, 1, 10'h000, 64'h155, 0, 0));
    tbl.push_back(mk(0, 10'h233, 64'h177, 1, 0, 0, 1, 2, 0, 1, 10'h000, 64'h155, 0, 1));
    tbl.push_back(mk(0, 10'h244, 64'h188, 1, 0, 0, 1, 3, 0, 1, 10'h000, 64'h155, 0, 1));
    tbl.push_back(mk(0, 10'h255, 64'h199, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h155, 0, 1));
    tbl.push_back(mk(0, 10'h266, 64'h1AA, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h155, 0, 0));
    tbl.push_back(mk(0, 10'h277, 64'h1BB, 1, 0, 0, 0, 0, 0, 0, 10'h277, 64'h1BB, 1, 0));
    tbl.push_back(mk(0, 10'h288, 64'h1CC, 1, 0, 0, 1, 3, 0, 1, 10'h000, 64'h1BB, 0, 1));
    tbl.push_back(mk(1, 10'h299, 64'h1DD, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h0, 0, 0));
    tbl.push_back(mk(0, 10'h2AA, 64'h1EE, 1, 0, 0, 0, 0, 0, 0, 10'h2AA, 64'h1EE, 1, 0));
    tbl.push_back(mk(0, 10'h2BB, 64'h1FF, 1, 0, 1, 0, 0, 0, 0, 10'h000, 64'h1EE, 0, 0));
    tbl.push_back(mk(0, 10'h2CC, 64'h200, 1, 0, 0, 1, 3, 0, 1, 10'h000, 64'h1EE, 0, 1));
    tbl.push_back(mk(0, 10'h2DD, 64'h211, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h1EE, 0, 1));
    tbl.push_back(mk(0, 10'h2EE, 64'h222, 1, 0, 0, 0, 0, 0, 1, 10'h000, 64'h1EE, 0, 0));
    tbl.push_back(mk(0, 10'h2FF, 64'h233, 1, 0, 0, 0, 0, 1, 0, 10'h000, 64'h1EE, 0, 0));

    foreach (tbl[i]) begin
      exp_t e;
      exp_t g;
      @(negedge clk);
      rst = tbl[i].r; ctrl_in = tbl[i].c; data_in = tbl[i].d;
      valid_in = tbl[i].v; stall = tbl[i].st; bubble = tbl[i].bb;
      inj_req = tbl[i].ij; inj_cnt = tbl[i].ic; flush = tbl[i].fl;
      #1;
      chk("upstream_hold", i, 64'(upstream_hold), 64'(tbl[i].h));
      e.ec = tbl[i].ec; e.ed = tbl[i].ed; e.ev = tbl[i].ev;
      e.eb = tbl[i].eb; e.idx = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("ctrl_out",  g.idx, 64'(ctrl_out),  64'(g.ec));
      chk("data_out",  g.idx, data_out,       g.ed);
      chk("valid_out", g.idx, 64'(valid_out), 64'(g.ev));
      chk("inj_busy",  g.idx, 64'(inj_busy),  64'(g.eb));
    end

    @(negedge clk);
    rst = 1'b0; stall = 1'b0; bubble = 1'b0; inj_req = 1'b0;
    inj_cnt = '0; flush = 1'b0;
`ifdef CTRL_BUBBLE_STATS_EN
    // after the last reset: 1 bubble + 3 injected + 1 flush
    chk("bubble_total", 0, 64'(bubble_total), 64'd5);
`endif
    @(negedge clk);
    chk("idle_hold", 0, 64'(upstream_hold), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
